wishbone_master_burst: RTL
==========================

Name: wishbone_master_burst

Overview:
Parametrised Wishbone classic-cycle bus master, successor to the single-beat debug-path master. Accepts commands over a valid/ready handshake instead of edge-latched start levels. Executes single or incrementing bursts of 1..MAX_BURST beats with byte selects, streams read beats out, pulls write beats in and reports bus errors. Sits between the JTAG/debug-module front end and the system Wishbone interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width; must be a multiple of 8
SEL_W, DATA_W/8, byte-select width; also the per-beat address increment
MAX_BURST, 16, maximum beats per command; power of 2
LEN_W, $clog2(MAX_BURST), width of cmd_len_i
TIMEOUT_CYCLES, 255, no-response limit (only used with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  master idle, command accepted when valid&ready
cmd_we_i  in  1  1=write burst, 0=read burst
cmd_addr_i  in  ADDR_W  start address
cmd_sel_i  in  SEL_W  byte selects applied to every beat
cmd_len_i  in  LEN_W  beats minus one
wdata_valid_i  in  1  write beat present
wdata_i  in  DATA_W  write beat
wdata_ready_o  out  1  master takes write beat
rdata_valid_o  out  1  one-cycle pulse per read beat
rdata_o  out  DATA_W  read beat
last_read_value_o  out  DATA_W  most recent read beat, held
done_o  out  1  one-cycle pulse at command end
err_o  out  1  sticky per command: burst ended by err_i or timeout
timeout_o  out  1  sticky per command: burst ended by timeout
adr_o  out  ADDR_W  Wishbone address
dat_o  out  DATA_W  Wishbone write data
dat_i  in  DATA_W  Wishbone read data
we_o  out  1  Wishbone write enable
sel_o  out  SEL_W  Wishbone byte selects
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
ack_i  in  1  Wishbone acknowledge
err_i  in  1  Wishbone error

Behaviour:
- All outputs registered. Reset (rst_i=0) forces all outputs to 0 immediately, state IDLE; reset mid-burst drops cyc_o/stb_o asynchronously, no done_o pulse.
- States: IDLE, WDATA, BUS, DONE. cmd_ready_o = (state==IDLE).
- IDLE: on accept, latch we/addr/sel/len, beat counter=0, clear err_o/timeout_o; read -> BUS, write -> WDATA. cyc_o/stb_o rise the cycle after accept.
- WDATA: cyc_o held 1 after first beat, stb_o=0, wdata_ready_o=1; on wdata_valid_i capture into dat_o -> BUS. Before the first write beat cyc_o=0.
- BUS: cyc_o=stb_o=1, adr_o/sel_o/we_o stable. err_i=1 -> DONE with err_o=1 (err_i wins over simultaneous ack_i). ack_i=1: read captures dat_i into rdata_o and last_read_value_o, rdata_valid_o pulses next cycle. If last beat (counter==len) -> DONE; else counter++, adr_o+=SEL_W (modulo 2^ADDR_W, wraps silently); read stays BUS (stb_o held, back-to-back one beat/clock max), write -> WDATA.
- DONE: cyc_o=stb_o=we_o=0, done_o=1 for one cycle, -> IDLE. err_o/timeout_o hold until next accept.
- ack_i/err_i outside BUS ignored. Command inputs ignored unless IDLE.

Optional Feature:
WB_MASTER_TIMEOUT_EN: counter clears on entry to BUS and on each ack; reaching TIMEOUT_CYCLES in BUS without ack_i/err_i aborts -> DONE, err_o=1, timeout_o=1. Without macro: waits in BUS indefinitely; timeout_o tied 0.

Decomposition:
Package wb_master_pkg: state enum, LEN_W/SEL_W derivation function, state encodings. One sub-module wb_timeout_counter (saturating counter, clear/enable/expired), instantiated only under WB_MASTER_TIMEOUT_EN.

Test Plan:
- Single read len=0 addr 0x1000, sel 0xFF, ack after 2 wait cycles, dat_i=0x1122334455667788 -> one rdata_valid_o pulse with that value, last_read_value_o held, done_o one cycle, err_o=0.
- Read burst len=3 addr 0x1000, ack every cycle -> adr_o 0x1000,0x1008,0x1010,0x1018 with stb_o continuously high, 4 rdata pulses, done_o after 4th.
- Write burst len=1, second wdata 3 cycles late -> stb_o low, cyc_o high during gap, dat_o matches each beat, done_o once.
- Read burst len=3, err_i with ack_i on beat 2 -> no rdata for beat 2, err_o=1, done_o, cyc_o low next cycle.
- Burst addr 0xFFFFFFF8 len=1 -> second adr_o 0x00000000; with WB_MASTER_TIMEOUT_EN and no ack, abort after 255 cycles with err_o=timeout_o=1.
- rst_i low during beat 2 of 4 -> cyc_o/stb_o 0 immediately, no done_o; new command accepted after release.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared definitions for the burst-capable Wishbone classic master.
// Contents: FSM state encoding and helpers deriving the byte-select and
// burst-length widths from the top-level parameters.
package wb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_BUS   = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  // Byte selects per beat; also the per-beat address step in bytes.
  function automatic int sel_width(input int data_w);
    return data_w / 8;
  endfunction

  // Width of a "beats minus one" field; never narrower than one bit.
  function automatic int len_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating no-response counter for the Wishbone master.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-low reset
//   clr_i         synchronous clear (dominates en_i)
//   en_i          count enable
//   expired_o     counter has reached LIMIT
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/wishbone_master_burst.sv
// Wishbone classic-cycle bus master with incrementing bursts of
// 1..MAX_BURST beats. Commands arrive over a valid/ready handshake, read
// beats stream out as one-cycle pulses, write beats are pulled in one at a
// time, and bus errors end the command early.
// Optional build macro WB_MASTER_TIMEOUT_EN: aborts a beat that gets no
// ack_i/err_i within TIMEOUT_CYCLES; otherwise the master waits forever and
// timeout_o stays 0.
// Ports:
//   clk_i, rst_i                        clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o             command handshake (ready when idle)
//   cmd_we_i, cmd_addr_i, cmd_sel_i     direction, start address, byte selects
//   cmd_len_i                           beats minus one
//   wdata_valid_i/wdata_i/wdata_ready_o write beat handshake
//   rdata_valid_o/rdata_o               read beat pulse
//   last_read_value_o                   most recent read beat, held
//   done_o, err_o, timeout_o            command end pulse, sticky status
//   adr_o..stb_o, dat_i, ack_i, err_i   Wishbone master side
//
// state    | meaning
// ST_IDLE  | waiting for a command
// ST_WDATA | waiting for the next write beat, strobe low
// ST_BUS   | strobe high, waiting for ack_i/err_i
// ST_DONE  | bus released, done_o pulsing
module wishbone_master_burst
  import wb_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int SEL_W          = sel_width(DATA_W),
  parameter int MAX_BURST      = 16,
  parameter int LEN_W          = len_width(MAX_BURST),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              wdata_valid_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              wdata_ready_o,
  output logic              rdata_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] last_read_value_o,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  output logic              we_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic              ack_i,
  input  logic              err_i
);

  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if ((MAX_BURST < 1) || ((MAX_BURST & (MAX_BURST - 1)) != 0)) begin : g_bad_burst
    $error("MAX_BURST must be a power of 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  wb_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              wready_q, wready_d;
  logic              expired;

`ifdef WB_MASTER_TIMEOUT_EN
  // Held clear outside BUS so every entry to BUS starts from zero.
  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     ((state_q != ST_BUS) || ack_i || err_i),
    .en_i      (state_q == ST_BUS),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    rdata_d  = rdata_q;
    last_d   = last_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    tmo_d    = tmo_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    wready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_d  = cmd_we_i;
          adr_d = cmd_addr_i;
          sel_d = cmd_sel_i;
          len_d = cmd_len_i;
          cnt_d = '0;
          err_d = 1'b0;
          tmo_d = 1'b0;
          if (cmd_we_i) begin
            state_d  = ST_WDATA;
            wready_d = 1'b1;
          end else begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
          end
        end
      end
      ST_WDATA: begin
        wready_d = 1'b1;
        if (wdata_valid_i) begin
          dat_d    = wdata_i;
          state_d  = ST_BUS;
          wready_d = 1'b0;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
        end
      end
      ST_BUS: begin
        // err_i beats ack_i; an ack in the expiry cycle still counts.
        if (err_i || (!ack_i && expired)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          tmo_d   = !err_i;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
        end else if (ack_i) begin
          if (!we_q) begin
            rdata_d  = dat_i;
            last_d   = dat_i;
            rvalid_d = 1'b1;
          end
          if (cnt_q == len_q) begin
            state_d = ST_DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            adr_d = adr_q + ADDR_W'(SEL_W);
            if (we_q) begin
              state_d  = ST_WDATA;
              stb_d    = 1'b0;
              wready_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      dat_q    <= '0;
      rdata_q  <= '0;
      last_q   <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      wready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      rdata_q  <= rdata_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      wready_q <= wready_d;
    end
  end

  assign cmd_ready_o       = (state_q == ST_IDLE);
  assign wdata_ready_o     = wready_q;
  assign rdata_valid_o     = rvalid_q;
  assign rdata_o           = rdata_q;
  assign last_read_value_o = last_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign timeout_o         = tmo_q;
  assign adr_o             = adr_q;
  assign dat_o             = dat_q;
  assign we_o              = we_q;
  assign sel_o             = sel_q;
  assign cyc_o             = cyc_q;
  assign stb_o             = stb_q;

endmodule
